mem_access_unit: RTL and testbench

Load/store unit of the MEM stage in the 5-stage RISC-V pipeline, between the EX/MEM register and the MEM/WB register. Formats loads and stores, issues byte-enabled requests to data memory over a ready-handshaked port, and stalls the pipeline while memory is busy. Produces the sign/zero-extended `RD` word and the gated `RegWriteMemM` consumed by the MEM/WB register, plus misalignment and bus-error flags.

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: formats loads/stores, drives a ready-handshaked data port, stalls
// the pipeline while memory is busy. Optional access timeout enabled by `define MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] RD,
    output logic        RegWriteMemM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rd_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic        we_q, err_q;

    logic        is_byte, is_half, access, misalign, valid, timeout_hit;
    logic [1:0]  off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    // Select the addressed lane and extend it according to the access size/sign code.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] sel,
                                             input logic [31:0] data);
        logic [31:0] lane;
        lane = data >> {sel, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{24{lane[7]}}, lane[7:0]};
            3'b001:  fmt_load = {{16{lane[15]}}, lane[15:0]};
            3'b100:  fmt_load = {24'h0, lane[7:0]};
            3'b101:  fmt_load = {16'h0, lane[15:0]};
            default: fmt_load = data;
        endcase
    endfunction

    assign off = ALUResultM[1:0];

    always_comb begin
        is_byte  = (Funct3M == 3'b000) || (Funct3M == 3'b100);
        is_half  = (Funct3M == 3'b001) || (Funct3M == 3'b101);
        access   = MemReadM | MemWriteM;
        misalign = is_half ? off[0] : (!is_byte && (off != 2'b00));
        valid    = access && !misalign;
        if (is_byte) begin
            req_be    = 4'b0001 << off;
            req_wdata = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            req_be    = off[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{WriteDataM[15:0]}};
        end else begin
            req_be    = 4'b1111;
            req_wdata = WriteDataM;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;

    // A ready in the last counted cycle takes priority over the abort.
    assign timeout_hit = (state_q == StWait) && !dmem_ready && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if ((state_q == StWait) && !dmem_ready && !timeout_hit) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (valid && !dmem_ready) state_d = StWait;
            StWait:  if (dmem_ready || timeout_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == StIdle) && valid && !dmem_ready) begin
                addr_q  <= ALUResultM;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                f3_q    <= Funct3M;
                we_q    <= MemWriteM;
            end
            if ((state_q == StWait) && dmem_ready) begin
                rd_q <= we_q ? 32'h0 : fmt_load(f3_q, addr_q[1:0], dmem_rdata);
            end
            err_q <= timeout_hit;
        end
    end

    // Outputs are forced low while reset is held, even though IDLE is input-driven.
    always_comb begin
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_be      = '0;
        dmem_wdata   = '0;
        RD           = '0;
        RegWriteMemM = 1'b0;
        StallM       = 1'b0;
        MisalignM    = 1'b0;
        BusErrM      = 1'b0;
        if (reset) begin
            unique case (state_q)
                StIdle: begin
                    MisalignM    = access && misalign;
                    RegWriteMemM = RegWriteM && !(access && misalign) && !(valid && !dmem_ready);
                    if (valid) begin
                        dmem_req   = 1'b1;
                        dmem_we    = MemWriteM;
                        dmem_addr  = {ALUResultM[31:2], 2'b00};
                        dmem_be    = req_be;
                        dmem_wdata = req_wdata;
                        StallM     = !dmem_ready;
                        if (dmem_ready && !MemWriteM) RD = fmt_load(Funct3M, off, dmem_rdata);
                    end
                end
                StWait: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_q;
                    dmem_addr  = {addr_q[31:2], 2'b00};
                    dmem_be    = be_q;
                    dmem_wdata = wdata_q;
                    StallM     = 1'b1;
                end
                StDone: begin
                    RD           = err_q ? 32'h0 : rd_q;
                    BusErrM      = err_q;
                    RegWriteMemM = RegWriteM && !err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a size/offset arithmetic model.
module tb_mem_access_unit;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] RD;
    logic        RegWriteMemM, StallM, MisalignM, BusErrM;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
        .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .RD(RD),
        .RegWriteMemM(RegWriteMemM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int s = size_of(f3);
        return 32'(((1 << s) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int s = size_of(f3);
        logic [31:0] b = {24'h0, wd[7:0]};
        logic [31:0] h = {16'h0, wd[15:0]};
        if (s == 1) return b * 32'h0101_0101;
        if (s == 2) return h * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int s = size_of(f3);
        logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 1);
        logic [31:0] v = (rdata >> (8 * (addr % 4))) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    // One instruction in MEM; memory answers k cycles after issue. Starts and ends at posedge+1.
    task automatic do_access(input bit rd, input bit wr, input bit rw, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdat, input int k);
        bit          is_mem = rd || wr;
        bit          mis    = is_mem && ((addr % size_of(f3)) != 0);
        bit          valid  = is_mem && !mis;
        logic [31:0] e_rd   = (valid && !wr) ? model_rd(f3, addr, rdat) : 32'h0;
        logic [31:0] e_be   = model_be(f3, addr);
        logic [31:0] e_wd   = model_wdata(f3, wd);
        logic [31:0] e_ad   = addr & 32'hFFFF_FFFC;
        RegWriteM  = rw;
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        dmem_ready = (k == 0);
        dmem_rdata = (k == 0) ? rdat : $urandom;
        @(negedge clk);
        check("req", dmem_req, valid);
        check("misalign", MisalignM, mis);
        check("buserr", BusErrM, 0);
        if (!valid) begin
            check("rd_nomem", RD, 0);
            check("rwm_nomem", RegWriteMemM, rw && !mis);
            check("stall_nomem", StallM, 0);
        end else begin
            check("we", dmem_we, wr);
            check("addr", dmem_addr, e_ad);
            check("be", dmem_be, e_be);
            if (wr) check("wdata", dmem_wdata, e_wd);
            check("stall_c0", StallM, k != 0);
            check("rwm_c0", RegWriteMemM, (k == 0) && rw);
            if (k == 0) check("rd_zero_wait", RD, e_rd);
            for (int c = 1; c <= k; c++) begin
                @(posedge clk); #1;
                dmem_ready = (c == k);
                dmem_rdata = (c == k) ? rdat : $urandom;
                @(negedge clk);
                check("req_wait", dmem_req, 1);
                check("stall_wait", StallM, 1);
                check("rwm_wait", RegWriteMemM, 0);
                check("addr_hold", dmem_addr, e_ad);
                check("be_hold", dmem_be, e_be);
                check("we_hold", dmem_we, wr);
                if (wr) check("wdata_hold", dmem_wdata, e_wd);
            end
            if (k > 0) begin
                @(posedge clk); #1;
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
                @(negedge clk);
                check("req_done", dmem_req, 0);
                check("stall_done", StallM, 0);
                check("rd_done", RD, e_rd);
                check("rwm_done", RegWriteMemM, rw);
                check("buserr_done", BusErrM, 0);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        // Reset held with a valid ready load on the inputs: everything must read 0.
        reset = 1'b0;
        RegWriteM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
        ALUResultM = 32'h0000_1000; WriteDataM = 32'hFFFF_FFFF;
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #3;
        check("rst_req", dmem_req, 0);
        check("rst_rd", RD, 0);
        check("rst_rwm", RegWriteMemM, 0);
        check("rst_stall", StallM, 0);
        check("rst_be", dmem_be, 0);
        check("rst_addr", dmem_addr, 0);
        MemReadM = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        do_access(1, 0, 1, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0);  // LB sign-extend
        do_access(0, 1, 0, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0);  // SH upper half
        do_access(1, 0, 1, 3'd2, 32'h0000_3000, 32'h0, 32'h89AB_CDEF, 3);  // LW, 3 wait cycles
        do_access(1, 0, 1, 3'd2, 32'h0000_1001, 32'h0, 32'h0, 0);          // LW misaligned
        do_access(1, 0, 1, 3'd5, 32'h0000_4002, 32'h0, 32'h8123_4567, 1);  // LHU
        do_access(1, 1, 1, 3'd0, 32'h0000_5001, 32'h0000_00A5, 32'h0, 2);  // both high = store
        do_access(0, 0, 1, 3'd2, 32'h0000_0000, 32'h0, 32'h0, 0);          // non-memory

        for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(0, 3);
            do_access(op == 1 || op == 3, op >= 2, 1'($urandom), f3_tab[$urandom_range(0, 7)],
                      $urandom, $urandom, $urandom, $urandom_range(0, 4));
        end

`ifdef MEM_TIMEOUT_EN
        do_access(1, 0, 1, 3'd2, 32'h0000_6000, 32'h0, 32'h1357_9BDF, TIMEOUT);
        RegWriteM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
        ALUResultM = 32'h0000_7000; dmem_ready = 1'b0;
        for (int c = 0; c <= TIMEOUT; c++) begin
            @(negedge clk);
            check("to_stall", StallM, 1);
            check("to_buserr_early", BusErrM, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_buserr", BusErrM, 1);
        check("to_req", dmem_req, 0);
        check("to_stall_done", StallM, 0);
        check("to_rwm", RegWriteMemM, 0);
        @(posedge clk); #1;
        do_access(0, 0, 1, 3'd2, 32'h0, 32'h0, 32'h0, 0);
`endif

        // Reset in the middle of a wait abandons the access at once.
        RegWriteM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
        ALUResultM = 32'h0000_0040; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre_rst_req", dmem_req, 1);
        reset = 1'b0;
        #1;
        check("midrst_req", dmem_req, 0);
        check("midrst_stall", StallM, 0);
        check("midrst_rd", RD, 0);
        MemReadM = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        do_access(1, 0, 1, 3'd4, 32'h0000_0000, 32'h0, 32'h1234_5685, 0);  // LBU after reset
        do_access(1, 0, 1, 3'd4, 32'h0000_0003, 32'h0, 32'hF234_5685, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
